his_reader_fsm: RTL

- Read-out side of the histogram memory.
- When the histogram builder toggles its bank flag (his_num), this block scans the just-completed bank pixel by pixel and bin by bin.
- Each bin count is streamed to the downstream data-processing stage over a valid/ready handshake, and each location is cleared as it is read, so the bank is empty before the builder returns to it.

---
 rtl/his_reader_fsm_pkg.sv | 14 +
 rtl/his_skid_buf.sv | 55 +++++
 rtl/his_reader_fsm.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/his_reader_fsm_pkg.sv
// his_reader_fsm_pkg.sv -- shared sizing defaults and FSM state codes
// for the histogram read-out (optional feature macro: PEAK_DETECT_EN).
package his_reader_fsm_pkg;

  localparam int DEF_BIN_NUM   = 64;
  localparam int DEF_PIXEL_NUM = 200;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_ADDR_W    = 14;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] DRAIN = 2'b10;

endpackage

// File: rtl/his_skid_buf.sv
// his_skid_buf.sv -- 2-entry valid/ready buffer; head entry drives the
// output and only moves on a pop, so a stalled output holds stable.
module his_skid_buf
  import his_reader_fsm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic         pop;

  assign pop       = out_valid & out_ready;
  assign out_valid = count != 2'd0;
  assign out_data  = d0;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      count <= 2'd0;
      d0    <= '0;
      d1    <= '0;
    end else begin
      unique case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) d0 <= in_data;
          else d1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          d0    <= d1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            d0 <= in_data;
          end else begin
            d0 <= d1;
            d1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/his_reader_fsm.sv
// his_reader_fsm.sv -- scans a completed histogram bank, streams and clears
// every bin. Define PEAK_DETECT_EN to add the per-pixel peak outputs.
module his_reader_fsm
  import his_reader_fsm_pkg::*;
#(
  parameter int  BIN_NUM   = DEF_BIN_NUM,
  parameter int  PIXEL_NUM = DEF_PIXEL_NUM,
  parameter int  CNT_W     = DEF_CNT_W,
  parameter int  ADDR_W    = DEF_ADDR_W,
  localparam int BIN_W     = $clog2(BIN_NUM),
  localparam int PIX_W     = $clog2(PIXEL_NUM)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              his_num,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              clr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [BIN_W-1:0]  out_bin,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_last_bin,
  output logic              out_last_frame,
  output logic              busy,
  output logic              overrun
`ifdef PEAK_DETECT_EN
  ,
  output logic              peak_valid,
  output logic [PIX_W-1:0]  peak_pixel,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [CNT_W-1:0]  peak_count
`endif
);

  localparam int PW = CNT_W + BIN_W + PIX_W + 2;

  logic              his_num_q;
  logic              start;
  logic              pend;
  logic              pend_bank;
  logic [1:0]        state;
  logic [BIN_W-1:0]  bin;
  logic [PIX_W-1:0]  pixel;
  logic [ADDR_W-1:0] addr;
  logic              v1;
  logic              lb1;
  logic              lf1;
  logic [BIN_W-1:0]  bin1;
  logic [PIX_W-1:0]  pix1;
  logic [1:0]        occ;
  logic              pop;
  logic              space;
  logic              bin_end;
  logic              last_rd;
  logic              drained;
  logic              final_xfer;
  logic [PW-1:0]     sk_in;
  logic [PW-1:0]     sk_out;

  assign start      = his_num ^ his_num_q;
  assign pop        = out_valid & out_ready;
  // a slot freed by this cycle's pop can take the read landing next cycle
  assign space      = ({1'b0, occ} + {2'b00, v1})
                      <= (3'd1 + {2'b00, pop});
  assign rd_en      = (state == READ) & space;
  assign clr_en     = rd_en;
  assign rd_addr    = addr;
  assign busy       = state != IDLE;
  assign bin_end    = bin == BIN_W'(BIN_NUM - 1);
  assign last_rd    = bin_end & (pixel == PIX_W'(PIXEL_NUM - 1));
  assign drained    = ~v1 & (occ == 2'd0);
  assign final_xfer = pop & out_last_frame;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      his_num_q <= 1'b0;
      state     <= IDLE;
      rd_bank   <= 1'b0;
      overrun   <= 1'b0;
      pend      <= 1'b0;
      pend_bank <= 1'b0;
      bin       <= '0;
      pixel     <= '0;
      addr      <= '0;
    end else begin
      his_num_q <= his_num;
      if (rd_en) begin
        addr <= addr + ADDR_W'(1);
        bin  <= bin_end ? '0 : bin + BIN_W'(1);
        if (bin_end) pixel <= pixel + PIX_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            rd_bank <= ~his_num;
            bin     <= '0;
            pixel   <= '0;
            addr    <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (start) begin
            overrun   <= 1'b1;
            pend      <= 1'b1;
            pend_bank <= ~his_num;
            state     <= DRAIN;
          end else if (rd_en && last_rd) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // a toggle alongside the final transfer is a clean new start
          if (start && !final_xfer) overrun <= 1'b1;
          if (drained && (pend || start)) begin
            rd_bank <= start ? ~his_num : pend_bank;
            bin     <= '0;
            pixel   <= '0;
            addr    <= '0;
            pend    <= 1'b0;
            state   <= READ;
          end else if (drained) begin
            state <= IDLE;
          end else if (start) begin
            pend      <= 1'b1;
            pend_bank <= ~his_num;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      v1   <= 1'b0;
      lb1  <= 1'b0;
      lf1  <= 1'b0;
      bin1 <= '0;
      pix1 <= '0;
    end else begin
      v1 <= rd_en;
      if (rd_en) begin
        bin1 <= bin;
        pix1 <= pixel;
        lb1  <= bin_end;
        lf1  <= last_rd;
      end
    end
  end

  assign sk_in = {rd_data, bin1, pix1, lb1, lf1};

  his_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .res       (res),
    .in_valid  (v1),
    .in_data   (sk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (sk_out),
    .count     (occ)
  );

  assign {out_count, out_bin, out_pixel,
          out_last_bin, out_last_frame} = sk_out;

`ifdef PEAK_DETECT_EN
  logic [CNT_W-1:0] best_cnt;
  logic [BIN_W-1:0] best_bin;
  logic [CNT_W-1:0] cand_cnt;
  logic [BIN_W-1:0] cand_bin;
  logic             take;

  // strict compare keeps the lowest bin on ties
  assign take     = (out_bin == '0) || (out_count > best_cnt);
  assign cand_cnt = take ? out_count : best_cnt;
  assign cand_bin = take ? out_bin : best_bin;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      best_cnt   <= '0;
      best_bin   <= '0;
      peak_valid <= 1'b0;
      peak_pixel <= '0;
      peak_bin   <= '0;
      peak_count <= '0;
    end else begin
      peak_valid <= pop & out_last_bin;
      if (pop) begin
        best_cnt <= cand_cnt;
        best_bin <= cand_bin;
      end
      if (pop && out_last_bin) begin
        peak_pixel <= out_pixel;
        peak_bin   <= cand_bin;
        peak_count <= cand_cnt;
      end
    end
  end
`endif

endmodule
